// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
// Shared types and constants for the fetch-side PC sequencer.
//   - pc_sel encoding driven to the MuxPC next-PC selector
//   - sequencer state enum (BOOT, RUN, PEND, HALT)
//   - redirect record {valid, kind, target} passed between the arbiter,
//     the pending slot and the top-level FSM
package pc_seq_pkg;

    // Width of a PC / redirect target.
    localparam int PC_W = 32;

    // MuxPC select encoding; also used as the redirect "kind" field.
    localparam logic [2:0] SEL_PC4  = 3'd0;
    localparam logic [2:0] SEL_BR   = 3'd1;
    localparam logic [2:0] SEL_JMP  = 3'd2;
    localparam logic [2:0] SEL_JALR = 3'd3;
    localparam logic [2:0] SEL_EXCP = 3'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        HALT = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic            valid;
        logic [2:0]      kind;
        logic [PC_W-1:0] target;
    } redirect_t;

endpackage

// File: rtl/pc_sequencer_arbiter.sv
// redirect_arbiter
// Combinational fixed-priority select among the four incoming redirect
// requests (excp > jalr > br > jmp). Lower-priority requests are simply
// dropped. The jalr target has bit 0 cleared here so every consumer sees
// an architecturally legal target.
// Ports:
//   excp_valid / excp_target  exception/trap request
//   jalr_valid / jalr_target  jalr request
//   br_valid   / br_target    taken-branch request
//   jmp_valid  / jmp_target   jal request
//   winner                    selected redirect record (valid=0 if none)
module redirect_arbiter
    import pc_seq_pkg::*;
(
    input  logic            excp_valid,
    input  logic [PC_W-1:0] excp_target,
    input  logic            jalr_valid,
    input  logic [PC_W-1:0] jalr_target,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    output redirect_t       winner
);

    always_comb begin
        winner = '0;
        if (excp_valid) begin
            winner.valid  = 1'b1;
            winner.kind   = SEL_EXCP;
            winner.target = excp_target;
        end else if (jalr_valid) begin
            winner.valid  = 1'b1;
            winner.kind   = SEL_JALR;
            winner.target = {jalr_target[PC_W-1:1], 1'b0};
        end else if (br_valid) begin
            winner.valid  = 1'b1;
            winner.kind   = SEL_BR;
            winner.target = br_target;
        end else if (jmp_valid) begin
            winner.valid  = 1'b1;
            winner.kind   = SEL_JMP;
            winner.target = jmp_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch-side controller around the external MuxPC next-PC selector. Owns
// the fetch PC register, picks the effective redirect (incoming winner or
// the one buffered while fetch was stalled), drives pc_sel plus the held
// targets into MuxPC and latches MuxPC's result as the next PC.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   io_stall                      hazard stall, holds the PC
//   io_halt                       request to enter HALT (RUN only)
//   io_{excp,jalr,br,jmp}_valid/_target  redirect requests
//   io_pc_sel                     select to MuxPC
//   io_pc_pc4/_jalr/_br/_jmp/_excp  MuxPC data inputs
//   io_pc_out                     MuxPC result
//   io_pc                         current fetch PC
//   io_imem_req_valid/_ready      instruction-memory request handshake
//   io_flush                      redirect applied this cycle
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = PC_W,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            io_stall,
    input  logic            io_halt,
    input  logic            io_excp_valid,
    input  logic [XLEN-1:0] io_excp_target,
    input  logic            io_jalr_valid,
    input  logic [XLEN-1:0] io_jalr_target,
    input  logic            io_br_valid,
    input  logic [XLEN-1:0] io_br_target,
    input  logic            io_jmp_valid,
    input  logic [XLEN-1:0] io_jmp_target,
    output logic [2:0]      io_pc_sel,
    output logic [XLEN-1:0] io_pc_pc4,
    output logic [XLEN-1:0] io_pc_jalr,
    output logic [XLEN-1:0] io_pc_br,
    output logic [XLEN-1:0] io_pc_jmp,
    output logic [XLEN-1:0] io_pc_excp,
    input  logic [XLEN-1:0] io_pc_out,
    output logic [XLEN-1:0] io_pc,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic            io_flush
);

    seq_state_t      state;
    logic [XLEN-1:0] pc;
    redirect_t       pend;
    redirect_t       incoming;
    redirect_t       eff;
    logic            adv;
    logic            fetching;
    logic [XLEN-1:0] hold_br;
    logic [XLEN-1:0] hold_jmp;
    logic [XLEN-1:0] hold_jalr;
    logic [XLEN-1:0] hold_excp;

    redirect_arbiter u_arb (
        .excp_valid  (io_excp_valid),
        .excp_target (io_excp_target),
        .jalr_valid  (io_jalr_valid),
        .jalr_target (io_jalr_target),
        .br_valid    (io_br_valid),
        .br_target   (io_br_target),
        .jmp_valid   (io_jmp_valid),
        .jmp_target  (io_jmp_target),
        .winner      (incoming)
    );

    assign fetching = (state == RUN) || (state == PEND);
    assign adv      = io_imem_req_ready & ~io_stall;

    // Effective redirect. A buffered redirect wins over new arrivals except
    // an exception, which must never be lost. In HALT only an exception
    // counts; BOOT ignores everything.
    always_comb begin
        eff = '0;
        if (fetching) begin
            if (pend.valid && !(incoming.valid && incoming.kind == SEL_EXCP)) begin
                eff = pend;
            end else begin
                eff = incoming;
            end
        end else if (state == HALT && io_excp_valid) begin
            eff.valid  = 1'b1;
            eff.kind   = SEL_EXCP;
            eff.target = io_excp_target;
        end
    end

    // MuxPC drive: the selected data input carries the live effective
    // target, the others keep whatever they last carried.
    always_comb begin
        io_pc_sel  = eff.valid ? eff.kind : SEL_PC4;
        io_pc_br   = (eff.valid && eff.kind == SEL_BR)   ? eff.target : hold_br;
        io_pc_jmp  = (eff.valid && eff.kind == SEL_JMP)  ? eff.target : hold_jmp;
        io_pc_jalr = (eff.valid && eff.kind == SEL_JALR) ? eff.target : hold_jalr;
        io_pc_excp = (eff.valid && eff.kind == SEL_EXCP) ? eff.target : hold_excp;
    end

    assign io_pc_pc4         = pc + XLEN'(4);
    assign io_pc             = pc;
    assign io_imem_req_valid = fetching;
    assign io_flush          = eff.valid && ((state == HALT) || (fetching && adv));

    // Remember the last target presented on each MuxPC data input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_br   <= '0;
            hold_jmp  <= '0;
            hold_jalr <= '0;
            hold_excp <= '0;
        end else if (eff.valid) begin
            case (eff.kind)
                SEL_BR:   hold_br   <= eff.target;
                SEL_JMP:  hold_jmp  <= eff.target;
                SEL_JALR: hold_jalr <= eff.target;
                SEL_EXCP: hold_excp <= eff.target;
                default:  ;
            endcase
        end
    end

    // Sequencer FSM with PC register and one-entry pending slot. The PC
    // always takes MuxPC's output when it moves, so halting uses the PC4
    // path just like sequential fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
            pc    <= RESET_VECTOR;
            pend  <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN, PEND: begin
                    if (adv) begin
                        pc   <= io_pc_out;
                        pend <= '0;
                        if (!eff.valid && io_halt && state == RUN) begin
                            state <= HALT;
                        end else begin
                            state <= RUN;
                        end
                    end else if (eff.valid) begin
                        pend  <= eff;
                        state <= PEND;
                    end
                end
                HALT: begin
                    if (io_excp_valid) begin
                        pc    <= io_pc_out;
                        state <= RUN;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. Models the external MuxPC, drives
// directed scenarios followed by random redirect/stall/halt traffic, and
// compares every cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_PEND = 2;
    localparam int M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_stall = 1'b0;
    logic        io_halt = 1'b0;
    logic        io_excp_valid = 1'b0;
    logic [31:0] io_excp_target = '0;
    logic        io_jalr_valid = 1'b0;
    logic [31:0] io_jalr_target = '0;
    logic        io_br_valid = 1'b0;
    logic [31:0] io_br_target = '0;
    logic        io_jmp_valid = 1'b0;
    logic [31:0] io_jmp_target = '0;
    logic [2:0]  io_pc_sel;
    logic [31:0] io_pc_pc4;
    logic [31:0] io_pc_jalr;
    logic [31:0] io_pc_br;
    logic [31:0] io_pc_jmp;
    logic [31:0] io_pc_excp;
    logic [31:0] io_pc_out;
    logic [31:0] io_pc;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready = 1'b1;
    logic        io_flush;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_pv;
    logic [2:0]  m_pk;
    logic [31:0] m_pt;

    pc_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .io_stall          (io_stall),
        .io_halt           (io_halt),
        .io_excp_valid     (io_excp_valid),
        .io_excp_target    (io_excp_target),
        .io_jalr_valid     (io_jalr_valid),
        .io_jalr_target    (io_jalr_target),
        .io_br_valid       (io_br_valid),
        .io_br_target      (io_br_target),
        .io_jmp_valid      (io_jmp_valid),
        .io_jmp_target     (io_jmp_target),
        .io_pc_sel         (io_pc_sel),
        .io_pc_pc4         (io_pc_pc4),
        .io_pc_jalr        (io_pc_jalr),
        .io_pc_br          (io_pc_br),
        .io_pc_jmp         (io_pc_jmp),
        .io_pc_excp        (io_pc_excp),
        .io_pc_out         (io_pc_out),
        .io_pc             (io_pc),
        .io_imem_req_valid (io_imem_req_valid),
        .io_imem_req_ready (io_imem_req_ready),
        .io_flush          (io_flush)
    );

    always #5 clk = ~clk;

    // Stand-in for the MuxPC block.
    always_comb begin
        case (io_pc_sel)
            3'd1:    io_pc_out = io_pc_br;
            3'd2:    io_pc_out = io_pc_jmp;
            3'd3:    io_pc_out = io_pc_jalr;
            3'd4:    io_pc_out = io_pc_excp;
            default: io_pc_out = io_pc_pc4;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        io_excp_valid     = 1'b0;
        io_jalr_valid     = 1'b0;
        io_br_valid       = 1'b0;
        io_jmp_valid      = 1'b0;
        io_halt           = 1'b0;
        io_stall          = 1'b0;
        io_imem_req_ready = 1'b1;
    endtask

    // Called at a negedge with inputs already set: checks outputs for this
    // cycle against the model, then advances the model across the posedge.
    task automatic applyStimulus();
        bit          w_v, e_v, adv, act;
        logic [2:0]  w_k, e_k;
        logic [31:0] w_t, e_t, sel_t;
        #1;
        w_v = 1'b1; w_k = 3'd0; w_t = '0;
        if (io_excp_valid) begin
            w_k = 3'd4; w_t = io_excp_target;
        end else if (io_jalr_valid) begin
            w_k = 3'd3; w_t = io_jalr_target & 32'hFFFF_FFFE;
        end else if (io_br_valid) begin
            w_k = 3'd1; w_t = io_br_target;
        end else if (io_jmp_valid) begin
            w_k = 3'd2; w_t = io_jmp_target;
        end else begin
            w_v = 1'b0;
        end
        act = (m_mode == M_RUN) || (m_mode == M_PEND);
        adv = io_imem_req_ready && !io_stall;
        e_v = 1'b0; e_k = 3'd0; e_t = '0;
        if (act) begin
            if (m_pv && !(w_v && w_k == 3'd4)) begin
                e_v = 1'b1; e_k = m_pk; e_t = m_pt;
            end else if (w_v) begin
                e_v = 1'b1; e_k = w_k; e_t = w_t;
            end
        end else if (m_mode == M_HALT && io_excp_valid) begin
            e_v = 1'b1; e_k = 3'd4; e_t = io_excp_target;
        end

        checkOutput("pc", io_pc, m_pc);
        checkOutput("pc4", io_pc_pc4, m_pc + 32'd4);
        checkOutput("req_valid", 32'(io_imem_req_valid), 32'(act));
        checkOutput("sel", 32'(io_pc_sel), 32'(e_k));
        checkOutput("flush", 32'(io_flush), 32'(e_v && (m_mode == M_HALT || (act && adv))));
        if (e_v) begin
            case (e_k)
                3'd1:    sel_t = io_pc_br;
                3'd2:    sel_t = io_pc_jmp;
                3'd3:    sel_t = io_pc_jalr;
                default: sel_t = io_pc_excp;
            endcase
            checkOutput("target", sel_t, e_t);
        end

        @(posedge clk);
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN, M_PEND: begin
                if (adv) begin
                    m_pc = e_v ? e_t : m_pc + 32'd4;
                    m_mode = (!e_v && io_halt && m_mode == M_RUN) ? M_HALT : M_RUN;
                    m_pv = 1'b0;
                end else if (e_v) begin
                    m_pv = 1'b1; m_pk = e_k; m_pt = e_t;
                    m_mode = M_PEND;
                end
            end
            default: begin
                if (io_excp_valid) begin
                    m_pc = io_excp_target;
                    m_mode = M_RUN;
                end
            end
        endcase
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must return to reset values immediately.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_pc", io_pc, RV);
        checkOutput("rst_req_valid", 32'(io_imem_req_valid), 32'd0);
        checkOutput("rst_flush", 32'(io_flush), 32'd0);
        checkOutput("rst_sel", 32'(io_pc_sel), 32'd0);
        checkOutput("rst_pc4", io_pc_pc4, RV + 32'd4);
        checkOutput("rst_targets", io_pc_br | io_pc_jmp | io_pc_jalr | io_pc_excp, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_mode = M_BOOT; m_pc = RV; m_pv = 1'b0; m_pk = '0; m_pt = '0;
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        do_reset();

        // Sequential fetch from the reset vector.
        repeat (4) applyStimulus();

        // br beats jmp.
        io_br_valid = 1'b1; io_br_target = 32'h8000_0100;
        io_jmp_valid = 1'b1; io_jmp_target = 32'h8000_0200;
        applyStimulus();
        clear_inputs();
        applyStimulus();

        // jalr buffered while imem not ready, bit0 cleared.
        io_jalr_valid = 1'b1; io_jalr_target = 32'h8000_0301; io_imem_req_ready = 1'b0;
        applyStimulus();
        io_jalr_valid = 1'b0;
        repeat (2) applyStimulus();
        io_imem_req_ready = 1'b1;
        applyStimulus();
        applyStimulus();

        // br pending, later br dropped, excp replaces the slot.
        io_stall = 1'b1;
        io_br_valid = 1'b1; io_br_target = 32'h8000_0500;
        applyStimulus();
        io_br_target = 32'h8000_0600;
        applyStimulus();
        io_br_valid = 1'b0;
        io_excp_valid = 1'b1; io_excp_target = 32'h0000_0040;
        applyStimulus();
        clear_inputs();
        applyStimulus();
        applyStimulus();

        // Halt at 8000_0010, br ignored, excp resumes.
        io_jmp_valid = 1'b1; io_jmp_target = 32'h8000_000C;
        applyStimulus();
        clear_inputs();
        applyStimulus();
        io_halt = 1'b1;
        applyStimulus();
        io_halt = 1'b0;
        io_br_valid = 1'b1; io_br_target = 32'h8000_0900;
        applyStimulus();
        io_br_valid = 1'b0;
        io_excp_valid = 1'b1; io_excp_target = 32'h0000_0080;
        applyStimulus();
        clear_inputs();
        applyStimulus();

        // PC wrap and reset while PEND.
        io_jmp_valid = 1'b1; io_jmp_target = 32'hFFFF_FFFC;
        applyStimulus();
        clear_inputs();
        repeat (2) applyStimulus();
        io_stall = 1'b1; io_br_valid = 1'b1; io_br_target = 32'h1234_5678;
        applyStimulus();
        do_reset();
        clear_inputs();
        repeat (2) applyStimulus();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            io_excp_valid     = ($urandom_range(0, 11) == 0);
            io_jalr_valid     = ($urandom_range(0, 7) == 0);
            io_br_valid       = ($urandom_range(0, 5) == 0);
            io_jmp_valid      = ($urandom_range(0, 7) == 0);
            io_excp_target    = $urandom & 32'hFFFF_FFFC;
            io_jalr_target    = $urandom;
            io_br_target      = $urandom & 32'hFFFF_FFFC;
            io_jmp_target     = $urandom & 32'hFFFF_FFFC;
            io_imem_req_ready = ($urandom_range(0, 3) != 0);
            io_stall          = ($urandom_range(0, 4) == 0);
            io_halt           = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side controller that sequences the MuxPC next-PC selector: owns the architectural fetch PC register, drives pc_sel and the held redirect targets into MuxPC, and latches MuxPC's output as the next PC.
- Arbitrates simultaneous redirect requests (exception, jalr, branch, jump) by fixed priority.
- Buffers one redirect while fetch is stalled; drives the instruction-memory request handshake and a flush pulse to the front-end pipeline.

Parameters:
- XLEN, 32, PC and target width
- RESET_VECTOR, 32'h8000_0000, PC value loaded on reset

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- io_stall  in  1  downstream hazard stall; holds PC
- io_halt  in  1  enter HALT (sampled in RUN only)
- io_excp_valid / io_excp_target  in  1 / XLEN  exception/trap redirect
- io_jalr_valid / io_jalr_target  in  1 / XLEN  jalr redirect
- io_br_valid / io_br_target  in  1 / XLEN  taken-branch redirect
- io_jmp_valid / io_jmp_target  in  1 / XLEN  jal redirect
- io_pc_sel  out  3  select to MuxPC
- io_pc_pc4 / io_pc_jalr / io_pc_br / io_pc_jmp / io_pc_excp  out  XLEN  MuxPC data inputs
- io_pc_out  in  XLEN  MuxPC result
- io_pc  out  XLEN  current fetch PC
- io_imem_req_valid  out  1  fetch request valid
- io_imem_req_ready  in  1  imem accepts request
- io_flush  out  1  redirect applied this cycle; kill younger fetches

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_VECTOR, state=BOOT, pending slot empty.
  - io_imem_req_valid=0, io_flush=0, io_pc_sel=SEL_PC4.
  - All target outputs are 0; io_pc_pc4 = RESET_VECTOR+4.
- States:
  - BOOT: req_valid=0 for exactly one cycle after reset release, then RUN.
  - RUN: req_valid=1.
  - PEND: req_valid=1 and a redirect is buffered.
  - HALT: req_valid=0.
- adv = io_imem_req_ready & ~io_stall. This is the only condition under which pc updates in RUN/PEND.
- Incoming priority: excp > jalr > br > jmp. Only the winner is considered; losers are dropped in the same cycle.
- jalr target has bit0 forced to 0 before use.
- Effective redirect:
  - pending entry if the slot is full, except that an incoming excp overrides it;
  - otherwise the incoming winner;
  - otherwise none.
- io_pc_sel: encoding of the effective redirect, else SEL_PC4. Combinational from state, pending slot and inputs.
- The target output matching io_pc_sel carries the effective target. Non-selected target outputs carry their last held values; they are don't-care.
- io_pc_pc4 = pc+4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- On adv: pc <= io_pc_out. The mux path has zero latency; the new PC is visible the next cycle.
  - If the effective redirect was non-PC4: io_flush=1 that cycle, pending cleared, state -> RUN.
- No adv with an effective redirect: store kind+target in the pending slot, state -> PEND, io_flush=0.
  - A non-excp redirect arriving while the slot is full is dropped, unless it is excp (excp replaces the slot).
- io_halt in RUN with no effective redirect, taken on adv: pc <= pc+4, state -> HALT.
- HALT: pc held, sel=PC4. io_excp_valid loads pc <= io_pc_out unconditionally (imem not requested), io_flush=1, state -> RUN. Other redirects are ignored.
- BOOT ignores all redirects.
- Reset mid-PEND or mid-HALT discards the pending slot and returns to BOOT.

Decomposition:
- Package pc_seq_pkg holds:
  - pc_sel encoding: SEL_PC4=3'd0, SEL_BR=3'd1, SEL_JMP=3'd2, SEL_JALR=3'd3, SEL_EXCP=3'd4;
  - state enum: BOOT, RUN, PEND, HALT;
  - the redirect record type {valid, kind[2:0], target[XLEN-1:0]}.
- One sub-module: redirect_arbiter. Combinational priority select of the four inputs, including the jalr bit0 clear, producing a record. The top holds the FSM, PC register and pending slot.

Test Plan:
- Reset, then hold ready=1, stall=0 -> BOOT cycle with req_valid=0; io_pc sequence 8000_0000, 8000_0004, 8000_0008; sel=0 throughout.
- br_valid and jmp_valid both asserted, br_target=8000_0100, jmp_target=8000_0200, ready=1 -> sel=1, flush=1, next io_pc=8000_0100.
- jalr_target=8000_0301 while ready=0 for 3 cycles -> state PEND, sel=3, io_pc_jalr=8000_0300, flush=0 until ready=1, then flush=1 and io_pc=8000_0300.
- In PEND with br pending, assert excp_target=0000_0040 while stalled -> slot replaced; on adv sel=4, io_pc=0000_0040. A br arriving in PEND is dropped.
- halt in RUN at pc=8000_0010 -> req_valid=0, io_pc=8000_0014 held; br ignored; excp_target=0000_0080 -> flush=1, io_pc=0000_0080, RUN.
- pc=FFFF_FFFC, adv -> io_pc_pc4=0, io_pc wraps to 0. Assert reset_n=0 mid-PEND -> io_pc=8000_0000 immediately, req_valid=0.
